// File: rtl/cv32e40s_data_obi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40s_data_obi_bridge
// Brief    : Write-buffer to OBI data-bus bridge with credit-limited response FIFO.
//            Optional zero-latency address phase: CV32E40S_DATA_OBI_ZERO_LAT_EN.
// Revision : 1.0
// ============================================================================
module cv32e40s_data_obi_bridge #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESP_DEPTH      = MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trans_valid_i,
  output logic        trans_ready_o,
  input  logic [31:0] trans_addr_i,
  input  logic        trans_we_i,
  input  logic [3:0]  trans_be_i,
  input  logic [31:0] trans_wdata_i,
  input  logic [1:0]  trans_memtype_i,
  input  logic [2:0]  trans_prot_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  output logic [1:0]  data_memtype_o,
  output logic [2:0]  data_prot_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        resp_we_o,
  output logic [1:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int               C_PTR_W     = 2;
  localparam int               C_SLOTS     = 4;
  localparam logic [2:0]       C_MAX       = 3'(MAX_OUTSTANDING);
  localparam logic [C_PTR_W-1:0] C_TAG_LAST  = C_PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [C_PTR_W-1:0] C_RESP_LAST = C_PTR_W'(RESP_DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [31:0]        addr_q;
  logic               we_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [1:0]         memtype_q;
  logic [2:0]         prot_q;

  logic [1:0]         outstanding_q, outstanding_d;
  logic [1:0]         resp_cnt_q, resp_cnt_d;
  logic [C_PTR_W-1:0] tag_wptr_q, tag_rptr_q;
  logic [C_PTR_W-1:0] resp_wptr_q, resp_rptr_q;
  logic               protocol_err_q;

  logic [C_SLOTS-1:0] tag_mem_q;
  logic [33:0]        resp_mem_q [C_SLOTS];

  logic [2:0]         w_inflight;
  logic               w_credit_ok;
  logic               w_accept;
  logic               w_load;
  logic               w_grant;
  logic               w_rsp_accept;
  logic               w_spurious;
  logic               w_rsp_pop;

  function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] ptr,
                                                 input logic [C_PTR_W-1:0] last);
    return (ptr == last) ? '0 : ptr + C_PTR_W'(1);
  endfunction

  // Every transfer holds a credit from acceptance until its response leaves the FIFO.
  assign w_inflight   = {1'b0, outstanding_q} + {1'b0, resp_cnt_q} + {2'b00, (state_q == REQ)};
  assign w_credit_ok  = (w_inflight < C_MAX);
  assign trans_ready_o = ((state_q == IDLE) || data_gnt_i) && w_credit_ok;
  assign w_accept     = trans_valid_i && trans_ready_o;

  always_comb begin
    data_req_o     = (state_q == REQ);
    data_addr_o    = addr_q;
    data_we_o      = we_q;
    data_be_o      = be_q;
    data_wdata_o   = wdata_q;
    data_memtype_o = memtype_q;
    data_prot_o    = prot_q;
`ifdef CV32E40S_DATA_OBI_ZERO_LAT_EN
    // Request is credit-gated so an unaccepted transfer is never exposed to the bus.
    if (state_q == IDLE) begin
      data_req_o     = trans_valid_i && w_credit_ok;
      data_addr_o    = trans_addr_i;
      data_we_o      = trans_we_i;
      data_be_o      = trans_be_i;
      data_wdata_o   = trans_wdata_i;
      data_memtype_o = trans_memtype_i;
      data_prot_o    = trans_prot_i;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    w_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
`ifdef CV32E40S_DATA_OBI_ZERO_LAT_EN
          if (!data_gnt_i) begin
            state_d = REQ;
            w_load  = 1'b1;
          end
`else
          state_d = REQ;
          w_load  = 1'b1;
`endif
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          if (w_accept) begin
            w_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_grant      = data_req_o && data_gnt_i;
  assign w_rsp_accept = data_rvalid_i && (outstanding_q != 2'd0);
  assign w_spurious   = data_rvalid_i && (outstanding_q == 2'd0);
  assign w_rsp_pop    = resp_valid_o && resp_ready_i;

  always_comb begin
    outstanding_d = outstanding_q;
    if (w_grant && !w_rsp_accept && (outstanding_q != 2'd3)) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (!w_grant && w_rsp_accept) begin
      outstanding_d = outstanding_q - 2'd1;
    end
    resp_cnt_d = resp_cnt_q;
    if (w_rsp_accept && !w_rsp_pop) begin
      resp_cnt_d = resp_cnt_q + 2'd1;
    end else if (!w_rsp_accept && w_rsp_pop) begin
      resp_cnt_d = resp_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      we_q           <= 1'b1;
      be_q           <= '0;
      wdata_q        <= '0;
      memtype_q      <= '0;
      prot_q         <= '0;
      outstanding_q  <= '0;
      resp_cnt_q     <= '0;
      tag_wptr_q     <= '0;
      tag_rptr_q     <= '0;
      resp_wptr_q    <= '0;
      resp_rptr_q    <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_load) begin
        addr_q    <= trans_addr_i;
        we_q      <= trans_we_i;
        be_q      <= trans_be_i;
        wdata_q   <= trans_wdata_i;
        memtype_q <= trans_memtype_i;
        prot_q    <= trans_prot_i;
      end
      outstanding_q <= outstanding_d;
      resp_cnt_q    <= resp_cnt_d;
      if (w_grant) begin
        tag_wptr_q <= ptr_inc(tag_wptr_q, C_TAG_LAST);
      end
      if (w_rsp_accept) begin
        tag_rptr_q  <= ptr_inc(tag_rptr_q, C_TAG_LAST);
        resp_wptr_q <= ptr_inc(resp_wptr_q, C_RESP_LAST);
      end
      if (w_rsp_pop) begin
        resp_rptr_q <= ptr_inc(resp_rptr_q, C_RESP_LAST);
      end
      if (w_spurious) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the reset counters and pointers.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      tag_mem_q[tag_wptr_q] <= data_we_o;
    end
    if (w_rsp_accept) begin
      resp_mem_q[resp_wptr_q] <= {data_rdata_i, data_err_i, tag_mem_q[tag_rptr_q]};
    end
  end

  assign resp_valid_o   = (resp_cnt_q != 2'd0);
  assign resp_rdata_o   = resp_mem_q[resp_rptr_q][33:2];
  assign resp_err_o     = resp_mem_q[resp_rptr_q][1];
  assign resp_we_o      = resp_mem_q[resp_rptr_q][0];
  assign outstanding_o  = outstanding_q;
  assign protocol_err_o = protocol_err_q;

endmodule
`default_nettype wire
